alu_mul_seq: RTL and testbench

Multi-cycle 16-bit unsigned multiplier sequencer that acts as the initiator for the datapath ALU. It captures two operands on a start request and drives the ALU operand and opcode inputs one operation per cycle, using ADD, MUL2 and DIV2 in a shift-and-add loop. It consumes the ALU result and zero flag, and returns the truncated product with a one-cycle done pulse. It sits between the control unit and the ALU, so multiply runs on the existing ALU without a dedicated multiplier.

---
 rtl/alu_mul_seq.sv | 143 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Sequential 16-bit unsigned multiplier that borrows the datapath ALU.
//   Uses shift-and-add: each loop iteration tests the multiplier Q.
//   When Q[0] is set, it adds the shifted multiplicand M into the accumulator P.
//   It then doubles M (MUL2) and halves Q (DIV2), all through the external ALU.
//   The product is truncated to 16 bits (modulo 2^16). There is no overflow flag.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   MA, MB     : multiplicand / multiplier, captured on accepted start
//   ALUA, ALUB : ALU operands (combinational from state and registers)
//   OP         : ALU opcode (combinational from state)
//   ALUR, Z    : ALU result and zero flag (ALU is combinational)
//   PROD       : registered product, updated on the TEST->FIN transition
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse while in FIN
//
// Handshake: start is a level request. It is accepted on the rising edge
// where the FSM is in IDLE and start=1. Nothing is accepted while busy=1.
// Completion is signalled by done being high for exactly the FIN cycle.
// PROD is valid from that cycle until the next completion.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] MA,
  input  logic [15:0] MB,
  output logic [15:0] ALUA,
  output logic [15:0] ALUB,
  output logic [3:0]  OP,
  input  logic [15:0] ALUR,
  input  logic        Z,
  output logic [15:0] PROD,
  output logic        busy,
  output logic        done
);

  // ALU opcode encodings
  localparam logic [3:0] OP_A    = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_DIV2 = 4'd8;
  localparam logic [3:0] OP_MUL2 = 4'd9;

  // FSM states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TEST = 3'd1;
  localparam logic [2:0] S_ADDS = 3'd2;
  localparam logic [2:0] S_SHM  = 3'd3;
  localparam logic [2:0] S_SHQ  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]  state;
  logic [15:0] p_q;   // accumulator
  logic [15:0] m_q;   // shifted multiplicand
  logic [15:0] q_q;   // shifted multiplier

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      p_q   <= 16'd0;
      m_q   <= 16'd0;
      q_q   <= 16'd0;
      PROD  <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            p_q   <= 16'd0;
            m_q   <= MA;
            q_q   <= MB;
            state <= S_TEST;
          end
        end
        S_TEST: begin
          // Z reflects Q passed through the ALU unchanged. Q==0 ends the loop.
          if (Z) begin
            PROD  <= p_q;
            state <= S_FIN;
          end else if (q_q[0]) begin
            state <= S_ADDS;
          end else begin
            state <= S_SHM;
          end
        end
        S_ADDS: begin
          p_q   <= ALUR;
          state <= S_SHM;
        end
        S_SHM: begin
          m_q   <= ALUR;
          state <= S_SHQ;
        end
        S_SHQ: begin
          q_q   <= ALUR;
          state <= S_TEST;
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU drive: operand and opcode selection by state
  always_comb begin
    OP   = OP_A;
    ALUA = 16'd0;
    ALUB = 16'd0;
    case (state)
      S_TEST: begin
        OP   = OP_A;
        ALUA = q_q;
      end
      S_ADDS: begin
        OP   = OP_ADD;
        ALUA = p_q;
        ALUB = m_q;
      end
      S_SHM: begin
        OP   = OP_MUL2;
        ALUA = m_q;
      end
      S_SHQ: begin
        OP   = OP_DIV2;
        ALUA = q_q;
      end
      default: begin
        OP   = OP_A;
        ALUA = 16'd0;
        ALUB = 16'd0;
      end
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
//   Directed bench for alu_mul_seq with a behavioural model of the datapath ALU.
//   Cycle numbering: the edge that samples start is edge 0.
//   Cycle c is the interval after edge c. Outputs are sampled on falling edges.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] MA;
  logic [15:0] MB;
  logic [15:0] ALUA;
  logic [15:0] ALUB;
  logic [3:0]  OP;
  logic [15:0] ALUR;
  logic        Z;
  logic [15:0] PROD;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  alu_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .MA    (MA),
    .MB    (MB),
    .ALUA  (ALUA),
    .ALUB  (ALUB),
    .OP    (OP),
    .ALUR  (ALUR),
    .Z     (Z),
    .PROD  (PROD),
    .busy  (busy),
    .done  (done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath ALU model: A pass, ADD, DIV2, MUL2
  always_comb begin
    case (OP)
      4'd0:    ALUR = ALUA;
      4'd2:    ALUR = ALUA + ALUB;
      4'd8:    ALUR = ALUA >> 1;
      4'd9:    ALUR = ALUA << 1;
      default: ALUR = ALUA;
    endcase
    Z = (ALUR == 16'd0);
  end

  // scoreboard: expected products queued at issue, popped at completion
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one multiply, starting from a point just after a falling edge.
  // poke_cycle > 0 issues a stray start (MA=2, MB=2) in that cycle.
  // It then scrambles the operands in the following cycle.
  // fin_start holds start high during the FIN cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [15:0] ma, input logic [15:0] mb,
                        input int exp_n, input int exp_add, input int exp_sh,
                        input int poke_cycle, input bit fin_start);
    int done_cyc;
    int done_cnt;
    int busy_cnt;
    int n_add;
    int n_shm;
    int n_shq;
    logic [15:0] exp_p;
    exp_q.push_back(ma * mb);
    done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    n_add = 0; n_shm = 0; n_shq = 0;
    start = 1'b1; MA = ma; MB = mb;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 100 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (OP == 4'd2) n_add++;
      if (OP == 4'd9) n_shm++;
      if (OP == 4'd8) n_shq++;
      if (done) begin
        done_cyc = c;
        done_cnt++;
      end
      if (c == poke_cycle) begin
        start = 1'b1; MA = 16'd2; MB = 16'd2;
      end else if (c == poke_cycle + 1) begin
        start = 1'b0; MA = 16'hAAAA; MB = 16'h5555;
      end
      if (done && fin_start) begin
        start = 1'b1; MA = 16'd3; MB = 16'd3;
      end
    end
    exp_p = exp_q.pop_front();
    check({tag, "_done_cycle"}, done_cyc, exp_n);
    check({tag, "_prod"}, PROD, exp_p);
    check({tag, "_busy_cycles"}, busy_cnt, exp_n);
    check({tag, "_n_add"}, n_add, exp_add);
    check({tag, "_n_shm"}, n_shm, exp_sh);
    check({tag, "_n_shq"}, n_shq, exp_sh);
    // cycle N+1: back in IDLE, PROD held
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_after"}, done, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_prod_held"}, PROD, exp_p);
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    rst_n = 1'b0; start = 1'b0; MA = 16'd0; MB = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_prod", PROD, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_op", OP, 4'd0);
    check("rst_alua", ALUA, 16'd0);
    check("rst_alub", ALUB, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MB=5: N = 3*3 + 2 + 2 = 13
    run_op("m3x5", 16'd3, 16'd5, 13, 2, 3, 0, 1'b0);
    // MB=0: straight to FIN in cycle 2, no loop opcodes
    run_op("m_mb0", 16'h1234, 16'd0, 2, 0, 0, 0, 1'b0);
    // MB=0xFFFF: N = 3*16 + 16 + 2 = 66, product truncates to 1; start held in FIN ignored
    run_op("m_ffff", 16'hFFFF, 16'hFFFF, 66, 16, 16, 0, 1'b1);
    // MB=9: N = 3*4 + 2 + 2 = 16, stray start in cycle 3 ignored
    run_op("m7x9", 16'd7, 16'd9, 16, 2, 4, 3, 1'b0);
    // start in the cycle right after FIN: MB=2, N = 3*2 + 1 + 2 = 9
    run_op("m2x2", 16'd2, 16'd2, 9, 1, 2, 0, 1'b0);
    // MB=0x0100: N = 3*9 + 1 + 2 = 30, product 0xCD00
    run_op("m_abcd", 16'hABCD, 16'h0100, 30, 1, 9, 0, 1'b0);
    // MB=0x8000: N = 3*16 + 1 + 2 = 51, product 0x8000
    run_op("m_top", 16'd1, 16'h8000, 51, 1, 16, 0, 1'b0);

    // asynchronous reset in cycle 5 of 100*200
    start = 1'b1; MA = 16'd100; MB = 16'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_prod", PROD, 16'd0);
    check("arst_op", OP, 4'd0);
    check("arst_alua", ALUA, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0; busy_seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    check("post_rst_no_done", done_seen, 0);
    check("post_rst_no_busy", busy_seen, 0);
    check("post_rst_prod", PROD, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
